counter_arbiter_seq: RTL and testbench
======================================

COUNTER_ARBITER_SEQ -- requirements
Module: counter_arbiter_seq

Interface
REQ-001: Parameter WIDTH, default 4, counter width in bits.
REQ-002: Parameter TERM, default 4'b1111, terminal count that ends a run.
REQ-003: C  input  1  clock; all state changes on rising edge.
REQ-004: CLR  input  1  reset, asynchronous, active-high.
REQ-005: REQ  input  2  per-requester run request; bit i belongs to requester i.
REQ-006: LDVAL0  input  WIDTH  start value for requester 0.
REQ-007: LDVAL1  input  WIDTH  start value for requester 1.
REQ-008: GNT  output  2  one-hot grant, held for the whole run.
REQ-009: BUSY  output  1  high in every state except IDLE.
REQ-010: DONE  output  1  single-cycle pulse at run completion.
REQ-011: DONE_ID  output  1  id of the finishing requester, valid while DONE=1.
REQ-012: Q  output  WIDTH  shared counter value.

Function
REQ-013: FSM states: IDLE, LOAD, COUNT, FIN; all outputs registered.
REQ-014: IDLE with REQ=00 -> stay IDLE; GNT=00 and counter holds.
REQ-015: IDLE with one REQ bit set -> grant that requester and enter LOAD.
REQ-016: IDLE with REQ=11 -> grant the requester not served last (round-robin), then enter LOAD.
REQ-017: LOAD: counter synchronously loads the granted requester's LDVAL, then COUNT.
REQ-018: COUNT: Q increments by 1 (mod 2^WIDTH) each cycle while Q != TERM.
REQ-019: COUNT with Q == TERM -> counter holds, enter FIN.
REQ-020: FIN: DONE=1, DONE_ID=granted id, GNT=00, last-served updated, then IDLE.
REQ-021: Latency: the grant edge to the DONE-high edge is (TERM - LDVAL) mod 2^WIDTH + 2 cycles.
REQ-022: LDVAL == TERM -> a single COUNT cycle, no increment, then FIN.
REQ-023: REQ is sampled only in IDLE; REQ deassertion mid-run is ignored and the run completes.
REQ-024: LDVALx is sampled only in LOAD; changes in other states have no effect.
REQ-025: REQ still high after FIN is re-arbitrated in the following IDLE cycle; there is no back-to-back grant without that IDLE cycle.
REQ-026: Q holds its final value (TERM) through FIN and IDLE until the next LOAD.

Reset
REQ-027: CLR=1 forces, asynchronously: state IDLE, GNT=00, BUSY=0, DONE=0, DONE_ID=0, Q=0, last-served=1 (requester 0 wins the first tie).
REQ-028: CLR mid-run aborts the run with no DONE pulse; the first edge after release evaluates IDLE.

Structure
REQ-029: The shared package holds the FSM state encoding (2-bit: IDLE=0, LOAD=1, COUNT=2, FIN=3) and requester id constants.
REQ-030: One sub-module, up_load_counter: WIDTH-bit up counter with C, CLR, synchronous load (SLOAD, D) and count enable CE; load has priority over CE.
REQ-031: The arbiter and FSM are in counter_arbiter_seq; no other hierarchy.

Verification
REQ-032: CLR pulse mid-COUNT (Q=7) -> outputs immediately at reset values; no DONE; next REQ=01 is served normally.
REQ-033: REQ=01, LDVAL0=10 -> GNT=01; Q steps 10..15; DONE=1 with DONE_ID=0 exactly 7 cycles after the grant edge; GNT=00.
REQ-034: REQ=11 held continuously after reset -> grants alternate 01, 10, 01; DONE_ID alternates 0, 1, 0.
REQ-035: LDVAL1=15, REQ=10 -> DONE 2 cycles after grant; Q stays 15.
REQ-036: REQ=01 dropped one cycle after grant, LDVAL0 changed during COUNT -> run completes from the original LDVAL0; DONE pulses once.
REQ-037: LDVAL0=0 -> 15 increments, Q reaches 15, DONE after 17 cycles, no wrap past TERM.

Source files
------------

// File: rtl/counter_arbiter_seq_pkg.sv
// Shared definitions for the two-requester counter arbiter: FSM encoding,
// requester ids and the round-robin pick.
package counter_arbiter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

    // On a tie the requester that was not served last wins.
    function automatic logic arbitrate(input logic [1:0] req, input logic last);
        case (req)
            2'b01:   return ID0;
            2'b10:   return ID1;
            default: return ~last;
        endcase
    endfunction

    function automatic logic [1:0] onehot(input logic id);
        return (id == ID1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/counter_arbiter_seq_up_load_counter.sv
// WIDTH-bit up counter with asynchronous clear, synchronous load and count
// enable; load wins over count.
module up_load_counter #(
    parameter int WIDTH = 4
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             SLOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             CE,
    output logic [WIDTH-1:0] Q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            Q <= '0;
        end else if (SLOAD) begin
            Q <= D;
        end else if (CE) begin
            Q <= Q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_arbiter_seq.sv
// Round-robin arbiter granting one of two requesters a counting run on a
// shared counter, from its load value up to TERM.
module counter_arbiter_seq
    import counter_arbiter_seq_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TERM  = 4'b1111
) (
    input  logic             C,
    input  logic             CLR,
    input  logic [1:0]       REQ,
    input  logic [WIDTH-1:0] LDVAL0,
    input  logic [WIDTH-1:0] LDVAL1,
    output logic [1:0]       GNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             DONE_ID,
    output logic [WIDTH-1:0] Q
);

    state_t           state, state_nxt;
    logic             gid, gid_nxt;
    logic             last, last_nxt;
    logic [1:0]       gnt_nxt;
    logic             busy_nxt, done_nxt, done_id_nxt;
    logic             at_term;
    logic             load_en, count_en;
    logic [WIDTH-1:0] load_val;

    assign at_term  = (Q == TERM);
    assign load_en  = (state == LOAD);
    assign count_en = (state == COUNT) && !at_term;
    assign load_val = (gid == ID1) ? LDVAL1 : LDVAL0;

    up_load_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .C    (C),
        .CLR  (CLR),
        .SLOAD(load_en),
        .D    (load_val),
        .CE   (count_en),
        .Q    (Q)
    );

    // State and registered outputs; last-served resets to 1 so requester 0
    // wins the first tie.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state   <= IDLE;
            GNT     <= 2'b00;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DONE_ID <= ID0;
            gid     <= ID0;
            last    <= ID1;
        end else begin
            state   <= state_nxt;
            GNT     <= gnt_nxt;
            BUSY    <= busy_nxt;
            DONE    <= done_nxt;
            DONE_ID <= done_id_nxt;
            gid     <= gid_nxt;
            last    <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|REQ) state_nxt = LOAD;
            LOAD:    state_nxt = COUNT;
            COUNT:   if (at_term) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they are registered yet
    // line up with the state they describe.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        gnt_nxt     = GNT;
        gid_nxt     = gid;
        last_nxt    = last;
        done_id_nxt = DONE_ID;
        case (state)
            IDLE: begin
                if (|REQ) begin
                    gid_nxt = arbitrate(REQ, last);
                    gnt_nxt = onehot(gid_nxt);
                end
            end
            COUNT: begin
                if (at_term) begin
                    gnt_nxt     = 2'b00;
                    done_id_nxt = gid;
                end
            end
            FIN:     last_nxt = gid;
            default: ;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == FIN);
    end

endmodule

// File: tb/tb_counter_arbiter_seq.sv
// Scoreboard bench for counter_arbiter_seq: stimulus queues the expected
// run (grant, id, latency) and a negedge monitor checks each DONE pulse.
module tb_counter_arbiter_seq;

    typedef struct {
        logic [1:0] gnt;
        logic       id;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [1:0] req;
    logic [3:0] ldval0, ldval1;
    logic [1:0] gnt;
    logic       busy, done, done_id;
    logic [3:0] q;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    counter_arbiter_seq #(
        .WIDTH(4),
        .TERM (4'b1111)
    ) dut (
        .C      (clk),
        .CLR    (clr),
        .REQ    (req),
        .LDVAL0 (ldval0),
        .LDVAL1 (ldval1),
        .GNT    (gnt),
        .BUSY   (busy),
        .DONE   (done),
        .DONE_ID(done_id),
        .Q      (q)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push(input logic [1:0] g, input logic id, input int lat);
        exp_t e;
        e.gnt = g;
        e.id  = id;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) return;
        end
        fail_timeout("wait_grant");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        fail_timeout("wait_idle");
    endtask

    // Monitor: tracks the grant cycle and checks each DONE against the queue.
    initial begin
        logic [1:0] prev_gnt = 2'b00;
        logic       prev_done = 1'b0;
        logic [1:0] grant_val = 2'b00;
        int         grant_cyc = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                grant_val = gnt;
                grant_cyc = cyc;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    e = sb.pop_front();
                    check("grant_value", grant_val, e.gnt);
                    check("done_id", done_id, e.id);
                    check("done_latency", cyc - grant_cyc, e.lat);
                    check("q_at_done", q, 15);
                    check("gnt_in_fin", gnt, 0);
                    check("busy_in_fin", busy, 1);
                    check("done_single_pulse", prev_done, 0);
                end
            end
            prev_gnt  = gnt;
            prev_done = done;
        end
    end

    initial begin
        int n_done;
        clr    = 1'b1;
        req    = 2'b00;
        ldval0 = 4'd0;
        ldval1 = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_q", q, 0);
        clr = 1'b0;
        @(negedge clk);

        // Requester 0 from 10: Q steps 10..15, DONE 7 cycles after grant.
        ldval0 = 4'd10;
        req    = 2'b01;
        push(2'b01, 1'b0, 7);
        wait_grant();
        req = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("q_step", q, 10 + k);
        end
        wait_idle();
        check("q_hold_idle", q, 15);

        // Requester 1 loading TERM: single COUNT cycle, Q stays 15.
        ldval1 = 4'd15;
        req    = 2'b10;
        push(2'b10, 1'b1, 2);
        wait_grant();
        req = 2'b00;
        @(negedge clk);
        check("q_load_term", q, 15);
        wait_idle();

        // REQ dropped and LDVAL0 changed mid-run: run completes from 12.
        ldval0 = 4'd12;
        req    = 2'b01;
        push(2'b01, 1'b0, 5);
        wait_grant();
        @(negedge clk);
        check("q_load_12", q, 12);
        req = 2'b00;
        @(negedge clk);
        ldval0 = 4'd3;
        wait_idle();
        check("q_after_ldval_change", q, 15);

        // Full run from 0: 15 increments, no wrap past TERM.
        ldval0 = 4'd0;
        req    = 2'b01;
        push(2'b01, 1'b0, 17);
        wait_grant();
        req = 2'b00;
        wait_idle();
        check("q_no_wrap", q, 15);

        // CLR while counting at Q=7 aborts with no DONE.
        ldval0 = 4'd5;
        req    = 2'b01;
        wait_grant();
        req = 2'b00;
        for (int i = 0; i < 20 && q != 4'd7; i++) @(negedge clk);
        check("q_reached_7", q, 7);
        clr = 1'b1;
        #1;
        check("abort_gnt", gnt, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", q, 0);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_stays_idle", busy, 0);
        ldval0 = 4'd13;
        req    = 2'b01;
        push(2'b01, 1'b0, 4);
        wait_grant();
        req = 2'b00;
        wait_idle();

        // REQ=11 held after reset: grants alternate 0, 1, 0.
        clr = 1'b1;
        #1;
        clr = 1'b0;
        ldval0 = 4'd14;
        ldval1 = 4'd13;
        push(2'b01, 1'b0, 3);
        push(2'b10, 1'b1, 4);
        push(2'b01, 1'b0, 3);
        req    = 2'b11;
        n_done = 0;
        for (int i = 0; i < 60 && n_done < 3; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        req = 2'b00;
        check("rr_done_count", n_done, 3);
        wait_idle();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
